// File: rtl/meter555_pkg.sv
// Shared constants and types for the 555 period / high-time meter.
package meter555_pkg;

    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // IDLE waits for a first rise so a partial period is never reported.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [1:0] SEL_PER_LO = 2'b00;
    localparam logic [1:0] SEL_PER_HI = 2'b01;
    localparam logic [1:0] SEL_HI_LO  = 2'b10;
    localparam logic [1:0] SEL_HI_HI  = 2'b11;

    localparam logic [7:0] UIO_OE_MASK = 8'h0F;

endpackage

// File: rtl/meter555_sync.sv
// Two-flop synchroniser for the asynchronous 555 output, plus a delay flop
// used to detect rising edges of the synchronised level.
module meter555_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q_s,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    // Synchroniser chain followed by the edge-detect delay flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign q_s  = sync_q;
    assign rise = sync_q & ~dly_q;

endmodule

// File: rtl/tt_um_nicklausthompson_555_meter.sv
// Measures period and high time of the 555 output in clk cycles and exposes
// the latest published result one byte at a time.
module tt_um_nicklausthompson_555_meter
    import meter555_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    inout  wire  [3:0] ua
);

    logic       osc_s;
    logic       rise;
    logic [1:0] sel;
    logic       freeze;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_p_q, cnt_p_d;
    logic [CNT_W-1:0] cnt_h_q, cnt_h_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic unused_ok;

    assign sel    = ui_in[2:1];
    assign freeze = ui_in[3];

    assign unused_ok = &{1'b0, ena, ui_in[7:4], uio_in, ua};

    meter555_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ui_in[0]),
        .q_s   (osc_s),
        .rise  (rise)
    );

    // Next-state logic: counters, FSM and the freeze-gated publish registers.
    always_comb begin
        state_d = state_q;
        cnt_p_d = cnt_p_q;
        cnt_h_d = cnt_h_q;
        per_d   = per_q;
        hi_d    = hi_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    cnt_p_d = CNT_W'(1);
                    cnt_h_d = CNT_W'(1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (rise) begin
                    // A rise wins over a simultaneous overflow.
                    if (!freeze) begin
                        per_d   = cnt_p_q;
                        hi_d    = cnt_h_q;
                        valid_d = 1'b1;
                        ovf_d   = 1'b0;
                    end
                    cnt_p_d = CNT_W'(1);
                    cnt_h_d = CNT_W'(1);
                end else if (cnt_p_q == CNT_MAX) begin
                    // Period too long (or oscillator stopped): report saturation.
                    if (!freeze) begin
                        per_d = CNT_MAX;
                        hi_d  = cnt_h_q;
                        ovf_d = 1'b1;
                    end
                    cnt_p_d = '0;
                    cnt_h_d = '0;
                    state_d = IDLE;
                end else begin
                    cnt_p_d = cnt_p_q + CNT_W'(1);
                    cnt_h_d = cnt_h_q + CNT_W'(osc_s);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_p_d = '0;
                cnt_h_d = '0;
            end
        endcase
    end

    // State, counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_p_q <= '0;
            cnt_h_q <= '0;
            per_q   <= '0;
            hi_q    <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_p_q <= cnt_p_d;
            cnt_h_q <= cnt_h_d;
            per_q   <= per_d;
            hi_q    <= hi_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    // Byte select from the published results.
    always_comb begin
        uo_out = per_q[7:0];
        case (sel)
            SEL_PER_LO: uo_out = per_q[7:0];
            SEL_PER_HI: uo_out = per_q[15:8];
            SEL_HI_LO:  uo_out = hi_q[7:0];
            SEL_HI_HI:  uo_out = hi_q[15:8];
            default:    uo_out = per_q[7:0];
        endcase
    end

    assign uio_out = {4'b0000, rise, osc_s, ovf_q, valid_q};
    assign uio_oe  = UIO_OE_MASK;

endmodule
